// File: rtl/spu_dual_pipe_reg.sv
// spu_dual_pipe_reg
// Dual-issue inter-stage pipeline register for the SPU. It carries the
// writeback information for each issue lane through DEPTH clocked stages.
// Lane 0 is the even pipe and lane 1 is the odd pipe. The memory address
// belongs to the last lane and is carried once per stage.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   stall_in          hold every stage unchanged
//   bubble_in         stage 0 loads a NOP; later stages still advance
//   flush_in          turn every stage into a NOP (overrides stall/bubble)
//   in_*              stage-0 inputs; lane i is in field [i*W +: W]
//   out_*             contents of the last stage (DEPTH-1)
//   fwd_*             per-stage/per-lane taps; tap index is k*LANES+i
//   busy              OR of every stage/lane write-enable
module spu_dual_pipe_reg #(
  parameter int LANES   = 2,
  parameter int DATA_W  = 128,
  parameter int RADDR_W = 7,
  parameter int UID_W   = 3,
  parameter int MADDR_W = 32,
  parameter int DEPTH   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall_in,
  input  logic                             bubble_in,
  input  logic                             flush_in,
  input  logic [LANES*RADDR_W-1:0]         in_rtaddr,
  input  logic [LANES-1:0]                 in_wreg,
  input  logic [LANES*DATA_W-1:0]          in_rt,
  input  logic [LANES*UID_W-1:0]           in_uid,
  input  logic [MADDR_W-1:0]               in_maddr,
  output logic [LANES*RADDR_W-1:0]         out_rtaddr,
  output logic [LANES-1:0]                 out_wreg,
  output logic [LANES*DATA_W-1:0]          out_rt,
  output logic [LANES*UID_W-1:0]           out_uid,
  output logic [MADDR_W-1:0]               out_maddr,
  output logic [DEPTH*LANES-1:0]           fwd_wreg,
  output logic [DEPTH*LANES*RADDR_W-1:0]   fwd_rtaddr,
  output logic [DEPTH*LANES*DATA_W-1:0]    fwd_rt,
  output logic                             busy
);

  // Reject unsupported depths when the design is elaborated.
  if (DEPTH < 1 || DEPTH > 8) begin : g_badDepth
    $fatal(1, "spu_dual_pipe_reg: DEPTH must be in 1..8");
  end

  logic [LANES*RADDR_W-1:0] r_rtaddr [DEPTH];
  logic [LANES-1:0]         r_wreg   [DEPTH];
  logic [LANES*DATA_W-1:0]  r_rt     [DEPTH];
  logic [LANES*UID_W-1:0]   r_uid    [DEPTH];
  logic [MADDR_W-1:0]       r_maddr  [DEPTH];

  // Stage storage. Reset and flush both clear every field, so they share a
  // branch; stall freezes everything (bubble included); otherwise the chain
  // shifts by one and stage 0 takes either the inputs or a NOP.
  always_ff @(posedge clk) begin
    if (rst || flush_in) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_rtaddr[k] <= '0;
        r_wreg[k]   <= '0;
        r_rt[k]     <= '0;
        r_uid[k]    <= '0;
        r_maddr[k]  <= '0;
      end
    end else if (!stall_in) begin
      if (bubble_in) begin
        r_rtaddr[0] <= '0;
        r_wreg[0]   <= '0;
        r_rt[0]     <= '0;
        r_uid[0]    <= '0;
        r_maddr[0]  <= '0;
      end else begin
        r_rtaddr[0] <= in_rtaddr;
        r_wreg[0]   <= in_wreg;
        r_rt[0]     <= in_rt;
        r_uid[0]    <= in_uid;
        r_maddr[0]  <= in_maddr;
      end
      for (int k = 1; k < DEPTH; k++) begin
        r_rtaddr[k] <= r_rtaddr[k-1];
        r_wreg[k]   <= r_wreg[k-1];
        r_rt[k]     <= r_rt[k-1];
        r_uid[k]    <= r_uid[k-1];
        r_maddr[k]  <= r_maddr[k-1];
      end
    end
  end

  // Lane packing inside a stage already matches the tap packing, so each
  // stage's buses drop into consecutive LANES-wide slots of the tap buses.
  for (genvar k = 0; k < DEPTH; k++) begin : g_taps
    assign fwd_wreg[k*LANES +: LANES]                   = r_wreg[k];
    assign fwd_rtaddr[k*LANES*RADDR_W +: LANES*RADDR_W] = r_rtaddr[k];
    assign fwd_rt[k*LANES*DATA_W +: LANES*DATA_W]       = r_rt[k];
  end

  assign out_rtaddr = r_rtaddr[DEPTH-1];
  assign out_wreg   = r_wreg[DEPTH-1];
  assign out_rt     = r_rt[DEPTH-1];
  assign out_uid    = r_uid[DEPTH-1];
  assign out_maddr  = r_maddr[DEPTH-1];

  // Derived only from stored write-enables, so it follows the registers.
  assign busy = |fwd_wreg;

endmodule

// File: tb/tb_spu_dual_pipe_reg.sv
// tb_spu_dual_pipe_reg
// Scoreboard bench for spu_dual_pipe_reg at DEPTH=3. The driver applies
// one input set per cycle, advances a behavioural model of the pipe, and
// queues the expected visible state. A separate monitor pops one expectation
// after each rising edge and compares every output and tap against it.
module tb_spu_dual_pipe_reg;

  localparam int LANES   = 2;
  localparam int DATA_W  = 128;
  localparam int RADDR_W = 7;
  localparam int UID_W   = 3;
  localparam int MADDR_W = 32;
  localparam int DEPTH   = 3;

  typedef struct packed {
    logic [LANES*RADDR_W-1:0] rtaddr;
    logic [LANES-1:0]         wreg;
    logic [LANES*DATA_W-1:0]  rt;
    logic [LANES*UID_W-1:0]   uid;
    logic [MADDR_W-1:0]       maddr;
  } entry_t;

  typedef struct {
    entry_t                         outE;
    logic [DEPTH*LANES-1:0]         fwdWreg;
    logic [DEPTH*LANES*RADDR_W-1:0] fwdRtaddr;
    logic [DEPTH*LANES*DATA_W-1:0]  fwdRt;
    logic                           busy;
  } expect_t;

  logic                           clk = 1'b0;
  logic                           rst;
  logic                           stall_in;
  logic                           bubble_in;
  logic                           flush_in;
  logic [LANES*RADDR_W-1:0]       in_rtaddr;
  logic [LANES-1:0]               in_wreg;
  logic [LANES*DATA_W-1:0]        in_rt;
  logic [LANES*UID_W-1:0]         in_uid;
  logic [MADDR_W-1:0]             in_maddr;
  logic [LANES*RADDR_W-1:0]       out_rtaddr;
  logic [LANES-1:0]               out_wreg;
  logic [LANES*DATA_W-1:0]        out_rt;
  logic [LANES*UID_W-1:0]         out_uid;
  logic [MADDR_W-1:0]             out_maddr;
  logic [DEPTH*LANES-1:0]         fwd_wreg;
  logic [DEPTH*LANES*RADDR_W-1:0] fwd_rtaddr;
  logic [DEPTH*LANES*DATA_W-1:0]  fwd_rt;
  logic                           busy;

  int compared   = 0;
  int mismatched = 0;
  int pushed     = 0;
  int popped     = 0;
  int cycle      = 0;
  bit driverDone = 1'b0;

  expect_t expQ[$];
  entry_t  model[DEPTH];

  spu_dual_pipe_reg #(
    .LANES(LANES), .DATA_W(DATA_W), .RADDR_W(RADDR_W),
    .UID_W(UID_W), .MADDR_W(MADDR_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .bubble_in(bubble_in),
    .flush_in(flush_in), .in_rtaddr(in_rtaddr), .in_wreg(in_wreg),
    .in_rt(in_rt), .in_uid(in_uid), .in_maddr(in_maddr),
    .out_rtaddr(out_rtaddr), .out_wreg(out_wreg), .out_rt(out_rt),
    .out_uid(out_uid), .out_maddr(out_maddr), .fwd_wreg(fwd_wreg),
    .fwd_rtaddr(fwd_rtaddr), .fwd_rt(fwd_rt), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Compare one field; fields are zero-extended so one helper serves all.
  task automatic checkField(input string name, input logic [1023:0] act,
                            input logic [1023:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    end
  endtask

  // Advance the behavioural pipe by one edge and queue what it should show.
  // The pipe is a list of DEPTH slots, oldest last: reset/flush empties it
  // to NOPs, stall leaves it alone, otherwise everything moves one slot on
  // and the new entry (or a NOP for a bubble) enters at the front.
  task automatic modelEdge(input bit r, input bit s, input bit b, input bit f,
                           input entry_t newE);
    expect_t e;
    if (r || f) begin
      foreach (model[k]) model[k] = '0;
    end else if (!s) begin
      for (int k = DEPTH - 1; k > 0; k--) model[k] = model[k-1];
      model[0] = b ? entry_t'('0) : newE;
    end
    e.outE = model[DEPTH-1];
    e.busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      for (int i = 0; i < LANES; i++) begin
        e.fwdWreg[k*LANES + i] = model[k].wreg[i];
        e.fwdRtaddr[(k*LANES + i)*RADDR_W +: RADDR_W] = model[k].rtaddr[i*RADDR_W +: RADDR_W];
        e.fwdRt[(k*LANES + i)*DATA_W +: DATA_W] = model[k].rt[i*DATA_W +: DATA_W];
        if (model[k].wreg[i]) e.busy = 1'b1;
      end
    end
    expQ.push_back(e);
    pushed++;
  endtask

  // Drive one cycle of stimulus on the falling edge and record its effect.
  task automatic applyStimulus(input bit r, input bit s, input bit b, input bit f,
                               input entry_t newE);
    @(negedge clk);
    rst       = r;
    stall_in  = s;
    bubble_in = b;
    flush_in  = f;
    in_rtaddr = newE.rtaddr;
    in_wreg   = newE.wreg;
    in_rt     = newE.rt;
    in_uid    = newE.uid;
    in_maddr  = newE.maddr;
    modelEdge(r, s, b, f, newE);
  endtask

  function automatic entry_t randEntry();
    entry_t e;
    e.rtaddr = (LANES*RADDR_W)'($urandom);
    e.wreg   = LANES'($urandom);
    e.rt     = {rand128(), rand128()};
    e.uid    = (LANES*UID_W)'($urandom);
    e.maddr  = $urandom;
    return e;
  endfunction

  // Entry tagged with an ID on both lanes' rtaddr, always valid.
  function automatic entry_t idEntry(input int id);
    entry_t e;
    e = randEntry();
    e.wreg = '1;
    e.rtaddr = {RADDR_W'(id + 64), RADDR_W'(id)};
    return e;
  endfunction

  // Monitor: after every rising edge, pop one expectation and compare.
  task automatic checkOutput();
    expect_t e;
    e = expQ.pop_front();
    popped++;
    checkField("out_rtaddr", 1024'(out_rtaddr), 1024'(e.outE.rtaddr));
    checkField("out_wreg",   1024'(out_wreg),   1024'(e.outE.wreg));
    checkField("out_rt",     1024'(out_rt),     1024'(e.outE.rt));
    checkField("out_uid",    1024'(out_uid),    1024'(e.outE.uid));
    checkField("out_maddr",  1024'(out_maddr),  1024'(e.outE.maddr));
    checkField("fwd_wreg",   1024'(fwd_wreg),   1024'(e.fwdWreg));
    checkField("fwd_rtaddr", 1024'(fwd_rtaddr), 1024'(e.fwdRtaddr));
    checkField("fwd_rt",     1024'(fwd_rt),     1024'(e.fwdRt));
    checkField("busy",       1024'(busy),       1024'(e.busy));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (expQ.size() > 0) checkOutput();
    end
  end

  // Driver: directed scenarios first, then a long randomized run.
  initial begin
    entry_t ones;
    int r;
    int s;
    ones.rtaddr = '1;
    ones.wreg   = '1;
    ones.rt     = '1;
    ones.uid    = '1;
    ones.maddr  = '1;
    rst = 1'b1; stall_in = 1'b0; bubble_in = 1'b0; flush_in = 1'b0;
    in_rtaddr = '0; in_wreg = '0; in_rt = '0; in_uid = '0; in_maddr = '0;

    // Reset with all-ones inputs, then one idle cycle after deassert.
    applyStimulus(1, 0, 0, 0, ones);
    applyStimulus(1, 0, 0, 0, ones);
    applyStimulus(0, 0, 0, 0, '0);

    // Tagged stream with a three-cycle stall in the middle.
    for (int id = 1; id <= 3; id++) applyStimulus(0, 0, 0, 0, idEntry(id));
    for (int n = 0; n < 3; n++) applyStimulus(0, 1, 0, 0, idEntry(50 + n));
    for (int id = 4; id <= 7; id++) applyStimulus(0, 0, 0, 0, idEntry(id));

    // Bubble carrying a valid-looking input, then bubble+stall together.
    applyStimulus(0, 0, 1, 0, idEntry(9));
    applyStimulus(0, 1, 1, 0, idEntry(10));
    applyStimulus(0, 0, 0, 0, idEntry(11));

    // Fill with valid entries, then flush and stall together.
    for (int id = 12; id < 15; id++) applyStimulus(0, 0, 0, 0, idEntry(id));
    applyStimulus(0, 1, 1, 1, idEntry(20));
    applyStimulus(0, 0, 0, 0, idEntry(21));

    // Fill again, reset under stall, then one entry run through to the end.
    for (int id = 22; id < 26; id++) applyStimulus(0, 0, 0, 0, idEntry(id));
    applyStimulus(1, 1, 0, 0, idEntry(30));
    applyStimulus(0, 0, 0, 0, idEntry(31));
    for (int n = 0; n < DEPTH + 1; n++) applyStimulus(0, 0, 1, 0, randEntry());

    // Randomized traffic with occasional control events.
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 99));
      s = int'($urandom_range(0, 99));
      applyStimulus(r < 2, s < 20, $urandom_range(0, 99) < 15,
                    $urandom_range(0, 99) < 4, randEntry());
    end
    applyStimulus(0, 0, 0, 0, '0);

    // Let the monitor drain, then confirm every expectation was consumed.
    repeat (3) @(posedge clk);
    #2;
    driverDone = 1'b1;
    checkField("drain_queue", 1024'(expQ.size()), 1024'(0));
    checkField("drain_count", 1024'(popped), 1024'(pushed));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard time limit in case the clock or driver ever stalls.
  initial begin
    #200000;
    if (!driverDone) begin
      $display("[TB] FAIL timeout: got no completion expected completion");
      $fatal(1, "[TB] timeout");
    end
  end

endmodule
